// File: rtl/hex_disp_pkg.sv
// Shared constants for the seven-segment display path: digit geometry,
// active-low segment patterns (bit 6 = g ... bit 0 = a) and arbiter states.
package hex_disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment map; codes 10-15 blank.
module seg7_decode
  import hex_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  // Table lookup of the segment pattern for one digit code
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scan_arbiter.sv
// Shared 8-digit display controller: round-robin write arbiter for two
// requesters into a digit buffer, plus a free-running scan that pushes one
// buffer slot per cycle through a single decoder into the HEX registers.
module hex_scan_arbiter
  import hex_disp_pkg::*;
(
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic         REQ_A,
  input  logic         REQ_B,
  input  logic [2:0]   ADDR_A,
  input  logic [2:0]   ADDR_B,
  input  logic [3:0]   DATA_A,
  input  logic [3:0]   DATA_B,
  output logic         GNT_A,
  output logic         GNT_B,
  output logic         SCAN_DONE,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic [6:0]   HEX4,
  output logic [6:0]   HEX5,
  output logic [6:0]   HEX6,
  output logic [6:0]   HEX7
);

  arb_state_t         state;
  logic               last_b;
  logic [DIGIT_W-1:0] digit_buf [NUM_DIGITS];
  logic [2:0]         scan_idx;
  logic [DIGIT_W-1:0] scan_code;
  logic [6:0]         scan_seg;
  logic [6:0]         hex_q [NUM_DIGITS];

  assign scan_code = digit_buf[scan_idx];

  seg7_decode u_seg7_decode (
    .code (scan_code),
    .seg  (scan_seg)
  );

  // Arbiter FSM: IDLE picks a requester (ties go to the one not served
  // last), GRANT_x lasts exactly one cycle and returns to IDLE
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      GNT_A  <= 1'b0;
      GNT_B  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_A && (!REQ_B || last_b)) begin
            state <= GRANT_A;
            GNT_A <= 1'b1;
          end else if (REQ_B) begin
            state <= GRANT_B;
            GNT_B <= 1'b1;
          end
        end
        GRANT_A: begin
          state  <= IDLE;
          GNT_A  <= 1'b0;
          last_b <= 1'b0;
        end
        GRANT_B: begin
          state  <= IDLE;
          GNT_B  <= 1'b0;
          last_b <= 1'b1;
        end
        default: begin
          state <= IDLE;
          GNT_A <= 1'b0;
          GNT_B <= 1'b0;
        end
      endcase
    end
  end

  // Digit buffer: committed at the end of the grant cycle, so a scan of the
  // same slot in that cycle still reads the old code
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= BLANK_CODE;
    end else if (state == GRANT_A) begin
      digit_buf[ADDR_A] <= DATA_A;
    end else if (state == GRANT_B) begin
      digit_buf[ADDR_B] <= DATA_B;
    end
  end

  // Scan sequencer: one slot per cycle, wrap pulse after slot 7
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      scan_idx  <= '0;
      SCAN_DONE <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
    end else begin
      scan_idx          <= scan_idx + 3'd1;
      SCAN_DONE         <= (scan_idx == 3'd7);
      hex_q[scan_idx]   <= scan_seg;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule
